// File: rtl/adpcm_ram_arb.sv
// rtl/adpcm_ram_arb.sv - ADPCM sample RAM arbiter between the OPNA ADPCM-B port and a host port
// Optional watchdog abort of stalled memory transactions: ADPCM_ARB_TIMEOUT_EN
module adpcm_ram_arb #(
  parameter int AW      = 18,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] opn_addr,
  input  logic          opn_rd,
  input  logic          opn_wr,
  input  logic [7:0]    opn_wdata,
  output logic [7:0]    opn_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic          host_ack,
  output logic [7:0]    host_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  input  logic          mem_ack,
  output logic          busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nx;
  logic            opn_rd_q, opn_wr_q;
  logic [AW-1:0]   opn_addr_q;
  logic            opn_pend, opn_req_we;
  logic [AW-1:0]   opn_req_addr;
  logic [7:0]      opn_req_wdata;
  logic            last_opn;
  logic            gnt_opn;
  logic            rd_evt, wr_evt, opn_evt, host_pend;
  logic            grant_opn, grant_host, done, timeout;
  logic [7:0]      rdata_in;

  assign rd_evt    = opn_rd & (~opn_rd_q | (opn_addr != opn_addr_q));
  assign wr_evt    = opn_wr & ~opn_wr_q;
  assign opn_evt   = rd_evt | wr_evt;
  // host_req is still high during the ack cycle; it must not re-grant
  assign host_pend = host_req & ~host_ack;
  assign busy      = (state != IDLE);
  assign rdata_in  = mem_ack ? mem_rdata : 8'hFF;

`ifdef ADPCM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;

  assign timeout = (state == BUSY) && !mem_ack && (tmo_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || grant_opn || grant_host) tmo_cnt <= '0;
    else if (state == BUSY)                 tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign timeout = (TIMEOUT < 0);
`endif

  // An OPNA event racing a lone host request holds off the host when it is OPNA's turn
  always_comb begin
    state_nx   = state;
    grant_opn  = 1'b0;
    grant_host = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (opn_pend && (!host_pend || !last_opn))          grant_opn  = 1'b1;
        else if (host_pend && !(opn_evt && !last_opn))      grant_host = 1'b1;
        if (grant_opn || grant_host) state_nx = BUSY;
      end
      BUSY: begin
        if (mem_ack || timeout) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      opn_rd_q      <= 1'b0;
      opn_wr_q      <= 1'b0;
      opn_addr_q    <= '0;
      opn_pend      <= 1'b0;
      opn_req_we    <= 1'b0;
      opn_req_addr  <= '0;
      opn_req_wdata <= 8'h00;
      last_opn      <= 1'b0;
      gnt_opn       <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= 8'h00;
      opn_rdata     <= 8'h00;
      host_rdata    <= 8'h00;
      host_ack      <= 1'b0;
    end else begin
      state      <= state_nx;
      opn_rd_q   <= opn_rd;
      opn_wr_q   <= opn_wr;
      opn_addr_q <= opn_addr;
      host_ack   <= 1'b0;
      if (grant_opn) begin
        mem_req   <= 1'b1;
        mem_we    <= opn_req_we;
        mem_addr  <= opn_req_addr;
        mem_wdata <= opn_req_wdata;
        last_opn  <= 1'b1;
        gnt_opn   <= 1'b1;
        opn_pend  <= 1'b0;
      end
      if (grant_host) begin
        mem_req   <= 1'b1;
        mem_we    <= host_we;
        mem_addr  <= host_addr;
        mem_wdata <= host_wdata;
        last_opn  <= 1'b0;
        gnt_opn   <= 1'b0;
      end
      if (done) begin
        mem_req <= 1'b0;
        if (gnt_opn) begin
          if (!mem_we) opn_rdata <= rdata_in;
        end else begin
          host_ack <= 1'b1;
          if (!mem_we) host_rdata <= rdata_in;
        end
      end
      // Placed after the grant so a same-edge event re-arms pend (latest wins)
      if (opn_evt) begin
        opn_pend      <= 1'b1;
        opn_req_we    <= wr_evt;
        opn_req_addr  <= opn_addr;
        opn_req_wdata <= opn_wdata;
      end
    end
  end

endmodule

// File: tb/tb_adpcm_ram_arb.sv
// tb/tb_adpcm_ram_arb.sv - scoreboard bench for adpcm_ram_arb
module tb_adpcm_ram_arb;

  typedef struct {
    logic        we;
    logic [17:0] addr;
    logic [7:0]  wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] opn_addr;
  logic        opn_rd, opn_wr;
  logic [7:0]  opn_wdata, opn_rdata;
  logic        host_req, host_we, host_ack;
  logic [17:0] host_addr;
  logic [7:0]  host_wdata, host_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [17:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        busy;

  logic        resp_ack, force_ack, model_on;
  logic [7:0]  resp_rdata;
  int          total = 0, bad = 0, txn_done = 0, exp_done = 0, ack_cnt = 0;
  int          oi, hi;
  logic        b2b;
  logic [7:0]  exp_opn;
  txn_t        sb[$];

  assign mem_ack   = resp_ack | force_ack;
  assign mem_rdata = resp_rdata;

  always #5 clk = ~clk;

  adpcm_ram_arb #(.AW(18), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .opn_addr(opn_addr), .opn_rd(opn_rd), .opn_wr(opn_wr), .opn_wdata(opn_wdata), .opn_rdata(opn_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );

  function automatic logic [7:0] mem_model(input logic [17:0] a);
    return (a == 18'h01234) ? 8'hA5 : (a[7:0] ^ 8'h3C);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic we, input logic [17:0] a, input logic [7:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    sb.push_back(t);
    exp_done++;
  endtask

  // Memory responder: acks 3 cycles after mem_req, checks each request against the scoreboard
  initial begin
    int   wcnt, gap;
    logic act;
    logic [17:0] cur;
    txn_t t;
    resp_ack = 1'b0; resp_rdata = 8'h00; act = 1'b0; gap = 100; wcnt = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (act) begin
        if (resp_ack) begin
          resp_ack = 1'b0; act = 1'b0; txn_done++;
          gap = mem_req ? 0 : 1;
        end else begin
          wcnt++;
          if (wcnt == 3) begin resp_ack = 1'b1; resp_rdata = mem_model(cur); end
        end
      end else if (mem_req && model_on) begin
        act = 1'b1; wcnt = 0; cur = mem_addr;
        chk("idle_gap", 32'(gap >= 1), 1);
        chk("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          t = sb.pop_front();
          chk("mem_we", 32'(mem_we), 32'(t.we));
          chk("mem_addr", 32'(mem_addr), 32'(t.addr));
          if (t.we) chk("mem_wdata", 32'(mem_wdata), 32'(t.wdata));
        end
        gap = 0;
      end else if (!mem_req) begin
        gap++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (host_ack) ack_cnt++;
    end
  end

  task automatic wait_done(input string tag);
    int n = 0;
    while (txn_done < exp_done && n < 80) begin
      @(negedge clk); #1;
      if (b2b && busy && mem_addr == opn_addr && oi < 2) begin
        oi++; opn_addr = 18'h10100 + 18'(oi);
      end
      if (host_ack) begin
        if (b2b && hi < 2) begin
          hi++; host_addr = 18'h20100 + 18'(hi); host_wdata = 8'h60 + 8'(hi);
        end else host_req = 1'b0;
      end
      n++;
    end
    chk(tag, 32'(txn_done >= exp_done), 1);
  endtask

  initial begin
    int a0, n;
    rst_n = 1'b0; opn_addr = '0; opn_rd = 0; opn_wr = 0; opn_wdata = 0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = 0;
    force_ack = 0; model_on = 0; b2b = 0; oi = 0; hi = 0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_opn_rdata", 32'(opn_rdata), 0);
    chk("rst_host_rdata", 32'(host_rdata), 0);
    chk("rst_host_ack", 32'(host_ack), 0);

    // reset in the middle of a transaction, stale ack right after release
    rst_n = 1'b1; host_req = 1'b1; host_addr = 18'h00005;
    @(negedge clk);
    chk("host_latency", 32'(mem_req), 1);
    @(negedge clk);
    rst_n = 1'b0; host_req = 1'b0; a0 = ack_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    chk("rel_mem_req", 32'(mem_req), 0);
    chk("rel_busy", 32'(busy), 0);
    @(negedge clk);
    chk("rel_mem_req2", 32'(mem_req), 0);
    chk("rel_opn_rdata", 32'(opn_rdata), 0);
    chk("rel_no_ack", 32'(ack_cnt - a0), 0);
    model_on = 1'b1;

    // OPNA read
    opn_addr = 18'h01234; opn_rd = 1'b1; push(0, 18'h01234, 0);
    wait_done("opn_rd_done");
    chk("opn_rdata", 32'(opn_rdata), 32'h A5);
    repeat (3) @(negedge clk);
    chk("opn_rdata_held", 32'(opn_rdata), 32'hA5);

    // address steps with opn_rd held high
    opn_addr = 18'h00010; push(0, 18'h00010, 0);
    wait_done("step1_done");
    chk("step1_rdata", 32'(opn_rdata), 32'(mem_model(18'h00010)));
    opn_addr = 18'h00011; push(0, 18'h00011, 0);
    wait_done("step2_done");
    chk("step2_rdata", 32'(opn_rdata), 32'(mem_model(18'h00011)));
    opn_rd = 1'b0;
    @(negedge clk);

    // contention straight out of reset: OPNA first
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    opn_addr = 18'h00020; opn_rd = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 18'h3FFFF; host_wdata = 8'h5A;
    a0 = ack_cnt;
    push(0, 18'h00020, 0); push(1, 18'h3FFFF, 8'h5A);
    wait_done("cont_done");
    @(negedge clk);
    chk("cont_single_ack", 32'(ack_cnt - a0), 1);
    chk("cont_opn_rdata", 32'(opn_rdata), 32'(mem_model(18'h00020)));
    opn_rd = 1'b0;
    @(negedge clk);

    // back-to-back contention, six alternating grants
    b2b = 1'b1; oi = 0; hi = 0; a0 = ack_cnt;
    opn_addr = 18'h10100; opn_rd = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 18'h20100; host_wdata = 8'h60;
    for (int i = 0; i < 3; i++) begin
      push(0, 18'h10100 + 18'(i), 0);
      push(1, 18'h20100 + 18'(i), 8'h60 + 8'(i));
    end
    wait_done("b2b_done");
    b2b = 1'b0;
    @(negedge clk);
    chk("b2b_acks", 32'(ack_cnt - a0), 3);
    exp_opn = mem_model(18'h10102);
    chk("b2b_opn_rdata", 32'(opn_rdata), 32'(exp_opn));
    opn_rd = 1'b0;
    @(negedge clk);

    // simultaneous rd/wr rise: write wins, rdata untouched
    opn_addr = 18'h00030; opn_wdata = 8'h77; opn_rd = 1'b1; opn_wr = 1'b1;
    push(1, 18'h00030, 8'h77);
    wait_done("rw_done");
    @(negedge clk);
    chk("rw_rdata_kept", 32'(opn_rdata), 32'(exp_opn));
    opn_rd = 1'b0; opn_wr = 1'b0;
    @(negedge clk);

    // host read at top address
    host_req = 1'b1; host_we = 1'b0; host_addr = 18'h3FFFF;
    push(0, 18'h3FFFF, 0);
    wait_done("hrd_done");
    chk("host_rdata", 32'(host_rdata), 32'(mem_model(18'h3FFFF)));
    repeat (2) @(negedge clk);
    chk("host_rdata_held", 32'(host_rdata), 32'(mem_model(18'h3FFFF)));
    chk("sb_empty", 32'(sb.size()), 0);
    chk("end_busy", 32'(busy), 0);

`ifdef ADPCM_ARB_TIMEOUT_EN
    model_on = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 18'h00040;
    n = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (mem_req && n < 40) begin @(negedge clk); n++; end
    chk("tmo_cycles", 32'(n), 8);
    chk("tmo_ack", 32'(host_ack), 1);
    chk("tmo_rdata", 32'(host_rdata), 32'hFF);
    host_req = 1'b0;
    repeat (2) @(negedge clk);
`else
    n = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
